ps2_controller: RTL and testbench

Receive-only PS/2 keyboard interface for the 50 MHz fabric clock. Synchronizes and de-glitches the open-collector PS2_CLK/PS2_DAT lines, deframes 11-bit device-to-host frames, and presents each valid scan-code byte with a one-cycle strobe. Also drives two active-low seven-segment digits showing the last received byte. Key decoders (make/break, F0 handling) sit downstream and consume `received_data`/`received_data_en`.

---
 rtl/ps2_controller_pkg.sv | 23 ++
 rtl/ps2_controller_hex_to_seven_segment.sv | 12 +
 rtl/ps2_controller.sv | 157 +++++++++++++++
 tb/tb_ps2_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_controller_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package ps2_controller_pkg;

  localparam int PS2_FILTER_LEN     = 8;
  localparam int PS2_TIMEOUT_CYCLES = 6000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  // Index 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/ps2_controller_hex_to_seven_segment.sv
// Nibble to active-low seven-segment decoder.
// Purely combinational.
module hex_to_seven_segment
  import ps2_controller_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/ps2_controller.sv
// Receive-only PS/2 keyboard deframer with
// clock de-glitch, timeout and hex display.
module ps2_controller
  import ps2_controller_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       frame_error,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  // Open-collector lines are only listened to.
  assign PS2_CLK = 1'bz;
  assign PS2_DAT = 1'bz;

  logic [1:0]     clk_s;
  logic [1:0]     dat_s;
  logic [FCW-1:0] fcnt;
  logic           filt;
  logic           fall;

  ps2_state_e     state, state_n;
  logic [2:0]     bit_cnt, bit_n;
  logic [7:0]     shreg, sh_n;
  logic           par, par_n;
  logic [TCW-1:0] tcnt, tcnt_n;
  logic [7:0]     rd_n;
  logic           en_n, err_n;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], PS2_CLK};
      dat_s <= {dat_s[0], PS2_DAT};
    end
  end

  // Level flips only after FILTER_LEN differing samples in a row.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      fcnt <= '0;
      filt <= 1'b1;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s[1] == filt) begin
        fcnt <= '0;
      end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
        fcnt <= '0;
        filt <= clk_s[1];
        fall <= filt;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    par_n   = par;
    tcnt_n  = '0;
    rd_n    = received_data;
    en_n    = 1'b0;
    err_n   = 1'b0;
    if (state != ST_IDLE && !fall) begin
      tcnt_n = tcnt + 1'b1;
    end
    unique case (state)
      ST_IDLE: begin
        if (fall && !dat_s[1]) begin
          state_n = ST_DATA;
          bit_n   = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          sh_n  = {dat_s[1], shreg[7:1]};
          bit_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            state_n = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_n   = dat_s[1];
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_n = ST_IDLE;
          if (dat_s[1] && (^{shreg, par})) begin
            rd_n = shreg;
            en_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
    endcase
    if (state != ST_IDLE && !fall &&
        tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
      state_n = ST_IDLE;
      tcnt_n  = '0;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      bit_cnt          <= '0;
      shreg            <= '0;
      par              <= 1'b0;
      tcnt             <= '0;
      received_data    <= 8'h00;
      received_data_en <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      state            <= state_n;
      bit_cnt          <= bit_n;
      shreg            <= sh_n;
      par              <= par_n;
      tcnt             <= tcnt_n;
      received_data    <= rd_n;
      received_data_en <= en_n;
      frame_error      <= err_n;
    end
  end

  hex_to_seven_segment u_hex0 (
    .hex (received_data[3:0]),
    .seg (HEX0)
  );

  hex_to_seven_segment u_hex1 (
    .hex (received_data[7:4]),
    .seg (HEX1)
  );

endmodule

// File: tb/tb_ps2_controller.sv
// Directed and random PS/2 frames against a
// byte-level reference model of the receiver.
module tb_ps2_controller;

  localparam int HALF = 40;
  localparam int TO   = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_line = 1'b1;
  logic       dat_line = 1'b1;
  wire        ps2_clk;
  wire        ps2_dat;
  logic [7:0] data;
  logic       en;
  logic       err;
  logic [6:0] hex0;
  logic [6:0] hex1;

  assign ps2_clk = clk_line;
  assign ps2_dat = dat_line;

  ps2_controller #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50         (clk),
    .reset            (rst_n),
    .PS2_CLK          (ps2_clk),
    .PS2_DAT          (ps2_dat),
    .received_data    (data),
    .received_data_en (en),
    .frame_error      (err),
    .HEX0             (hex0),
    .HEX1             (hex1)
  );

  always #10 clk = ~clk;

  logic [6:0] seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int vectors = 0;
  int miscompares = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] exp_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pulse = 1'b0;
    end else begin
      if (en || err) begin
        vectors++;
        assert (!(en && err) && !prev_pulse) else begin
          miscompares++;
          $error("FAIL pulse_excl: en=%0b err=%0b prev=%0b required isolated single pulse",
                 en, err, prev_pulse);
        end
      end
      if (en) en_cnt++;
      if (err) err_cnt++;
      prev_pulse = en | err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    dat_line = b;
    repeat (HALF) @(negedge clk);
    clk_line = 1'b0;
    repeat (HALF) @(negedge clk);
    clk_line = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par,
                            input bit bad_stop, input int ndata);
    logic p;
    p = ($countones(b) % 2 == 0);
    if (flip_par) p = ~p;
    send_bit(1'b0);
    for (int i = 0; i < ndata; i++) send_bit(b[i]);
    if (ndata == 8) begin
      send_bit(p);
      send_bit(!bad_stop);
    end
    dat_line = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] b,
                           input bit flip_par, input bit bad_stop);
    int e0, r0;
    bit good;
    e0 = en_cnt;
    r0 = err_cnt;
    good = !flip_par && !bad_stop;
    send_frame(b, flip_par, bad_stop, 8);
    if (good) exp_data = b;
    chk({tag, "_en"}, en_cnt - e0, good ? 1 : 0);
    chk({tag, "_err"}, err_cnt - r0, good ? 0 : 1);
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_hex0"}, hex0, seg[exp_data[3:0]]);
    chk({tag, "_hex1"}, hex1, seg[exp_data[7:4]]);
  endtask

  initial begin
    int e0, r0;
    logic [7:0] rb;
    int mode;
    exp_data = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_en", en, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_hex0", hex0, 7'h40);
    chk("rst_hex1", hex1, 7'h40);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    frame_chk("f1c", 8'h1C, 0, 0);
    chk("f1c_hex0_lit", hex0, 7'h46);
    chk("f1c_hex1_lit", hex1, 7'h79);
    frame_chk("ff0", 8'hF0, 0, 0);
    chk("ff0_hex1_lit", hex1, 7'h0E);
    frame_chk("f1c_b", 8'h1C, 0, 0);
    frame_chk("f23_par", 8'h23, 1, 0);
    frame_chk("f23_stop", 8'h23, 0, 1);

    e0 = en_cnt;
    r0 = err_cnt;
    send_frame(8'hA5, 0, 0, 4);
    repeat (TO + 200) @(negedge clk);
    chk("to_err", err_cnt - r0, 1);
    chk("to_en", en_cnt - e0, 0);
    chk("to_data", data, exp_data);
    frame_chk("f5a", 8'h5A, 0, 0);

    e0 = en_cnt;
    r0 = err_cnt;
    dat_line = 1'b0;
    repeat (20) @(negedge clk);
    clk_line = 1'b0;
    repeat (5) @(negedge clk);
    clk_line = 1'b1;
    repeat (20) @(negedge clk);
    dat_line = 1'b1;
    repeat (TO + 200) @(negedge clk);
    chk("glitch_err", err_cnt - r0, 0);
    chk("glitch_en", en_cnt - e0, 0);
    frame_chk("f_post_glitch", 8'h3C, 0, 0);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    dat_line = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    exp_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("mrst_data", data, 8'h00);
    chk("mrst_en", en, 1'b0);
    chk("mrst_err", err, 1'b0);
    chk("mrst_hex0", hex0, 7'h40);
    chk("mrst_hex1", hex1, 7'h40);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    frame_chk("f76", 8'h76, 0, 0);
    chk("f76_hex0_lit", hex0, 7'h02);
    chk("f76_hex1_lit", hex1, 7'h78);

    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 3);
      frame_chk("rnd", rb, mode == 0, mode == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
